// File: rtl/cam_stream_gen_if.sv
// Camera-style video stream bundle: frame/line timing, pixel data and frame bookkeeping.
interface cam_stream_gen_if;
  logic        VSYNC;
  logic        pixel_valid;
  logic [15:0] pixel_in;
  logic        frame_done;
  logic [15:0] frame_cnt;

  modport master (output VSYNC, pixel_valid, pixel_in, frame_done, frame_cnt);
  modport slave  (input  VSYNC, pixel_valid, pixel_in, frame_done, frame_cnt);
endinterface

// File: rtl/cam_stream_gen.sv
// Synthetic camera source: VSYNC-framed RGB565 test patterns with per-line blanking and inter-frame gap.
module cam_stream_gen #(
  parameter int unsigned CAM_WIDTH  = 640,
  parameter int unsigned CAM_HEIGHT = 480,
  parameter int unsigned H_BLANK    = 144,
  parameter int unsigned V_GAP      = 1000
) (
  input  logic              PCLK,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  cam_stream_gen_if.master  stream
);

  localparam int unsigned HW    = (CAM_WIDTH  > 1) ? $clog2(CAM_WIDTH)  : 1;
  localparam int unsigned VW    = (CAM_HEIGHT > 1) ? $clog2(CAM_HEIGHT) : 1;
  localparam int unsigned BW    = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam int unsigned GW    = (V_GAP   > 1) ? $clog2(V_GAP)   : 1;
  localparam int unsigned BAR_W = (CAM_WIDTH >= 8) ? CAM_WIDTH / 8 : 1;

  localparam logic [HW-1:0] H_LAST = HW'(CAM_WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(CAM_HEIGHT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(H_BLANK - 1);
  localparam logic [GW-1:0] G_LAST = GW'(V_GAP - 1);

  localparam logic [15:0] BAR_COLOR [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  typedef enum logic [1:0] {IDLE, VGAP, ACTIVE, HBLANK} state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [BW-1:0] blank_cnt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    pat;
  logic [15:0]   pix_cnt;
  logic          vsync_r;
  logic          valid_r;
  logic          done_r;
  logic [15:0]   pixel_r;
  logic [15:0]   frame_count;

  // Pixel value for the position about to be presented; cnt is that pixel's frame index.
  function automatic logic [15:0] pixel_of(input logic [HW-1:0] h, input logic [VW-1:0] v,
                                           input logic [1:0] sel, input logic [15:0] cnt);
    logic [15:0] h16;
    logic [15:0] v16;
    int unsigned bar;
    h16 = 16'(h);
    v16 = 16'(v);
    bar = 32'(h) / BAR_W;
    if (bar > 7) bar = 7;
    case (sel)
      2'd0:    pixel_of = BAR_COLOR[bar[2:0]];
      2'd1:    pixel_of = (h16 << 8) | (v16 & 16'h00FF);
      2'd2:    pixel_of = (((h16 ^ v16) & 16'h0020) != 16'h0000) ? 16'hFFFF : 16'h0000;
      default: pixel_of = cnt;
    endcase
  endfunction

  always_ff @(posedge PCLK) begin
    if (rst) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      blank_cnt   <= '0;
      gap_cnt     <= '0;
      pat         <= '0;
      pix_cnt     <= '0;
      vsync_r     <= 1'b0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
      pixel_r     <= '0;
      frame_count <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          vsync_r <= 1'b0;
          valid_r <= 1'b0;
          pixel_r <= '0;
          if (enable) begin
            state   <= VGAP;
            gap_cnt <= '0;
          end
        end
        VGAP: begin
          if (gap_cnt == G_LAST) begin
            state   <= ACTIVE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            pat     <= pattern_sel;
            vsync_r <= 1'b1;
            valid_r <= 1'b1;
            pixel_r <= pixel_of('0, '0, pattern_sel, 16'h0000);
            pix_cnt <= 16'h0001;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (h_cnt == H_LAST) begin
            state     <= HBLANK;
            blank_cnt <= '0;
            valid_r   <= 1'b0;
            pixel_r   <= '0;
          end else begin
            h_cnt   <= h_cnt + 1'b1;
            pixel_r <= pixel_of(h_cnt + 1'b1, v_cnt, pat, pix_cnt);
            pix_cnt <= pix_cnt + 16'h0001;
          end
        end
        HBLANK: begin
          if (blank_cnt == B_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              // Frame ends here; enable is only consulted now, so a frame is never cut short.
              v_cnt       <= '0;
              vsync_r     <= 1'b0;
              done_r      <= 1'b1;
              frame_count <= frame_count + 16'h0001;
              gap_cnt     <= '0;
              state       <= enable ? VGAP : IDLE;
            end else begin
              v_cnt   <= v_cnt + 1'b1;
              state   <= ACTIVE;
              valid_r <= 1'b1;
              pixel_r <= pixel_of('0, v_cnt + 1'b1, pat, pix_cnt);
              pix_cnt <= pix_cnt + 16'h0001;
            end
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stream.VSYNC       = vsync_r;
  assign stream.pixel_valid = valid_r;
  assign stream.pixel_in    = pixel_r;
  assign stream.frame_done  = done_r;
  assign stream.frame_cnt   = frame_count;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench: a small 8x4 instance for frame timing/counter checks and a 640-wide instance for bar/blank checks.
module tb_cam_stream_gen;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic       rst0 = 1'b1, en0 = 1'b0;
  logic [1:0] sel0 = 2'd0;
  logic       rst1 = 1'b1, en1 = 1'b0;
  logic [1:0] sel1 = 2'd0;

  cam_stream_gen_if bus0 ();
  cam_stream_gen_if bus1 ();

  cam_stream_gen #(.CAM_WIDTH(8), .CAM_HEIGHT(4), .H_BLANK(2), .V_GAP(3)) dut0 (
    .PCLK(PCLK), .rst(rst0), .enable(en0), .pattern_sel(sel0), .stream(bus0.master));

  cam_stream_gen #(.CAM_WIDTH(640), .CAM_HEIGHT(3), .H_BLANK(144), .V_GAP(4)) dut1 (
    .PCLK(PCLK), .rst(rst1), .enable(en1), .pattern_sel(sel1), .stream(bus1.master));

  int vectors = 0;
  int errors  = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // Small-instance frame capture state
  logic [15:0] log0 [$];
  int lat0, vs0, nz0, done0, to0;

  // Large-instance stream monitor
  logic [15:0] fb1 [0:1919];
  int idx1 = 0, frames1 = 0, run1 = 0, blanks1 = 0, blank_bad1 = 0, nz1 = 0;

  always @(negedge PCLK) begin
    if (bus1.pixel_valid === 1'b1) begin
      if (idx1 < 1920) fb1[idx1] = bus1.pixel_in;
      idx1++;
    end else if (bus1.pixel_in !== 16'h0000) nz1++;
    if (bus1.VSYNC === 1'b1 && bus1.pixel_valid === 1'b0) run1++;
    else if (run1 > 0) begin
      blanks1++;
      if (run1 != 144) blank_bad1++;
      run1 = 0;
    end
    if (bus1.frame_done === 1'b1) begin
      frames1++;
      idx1 = 0;
    end
  end

  // Waits for VSYNC rise (lat0 = negedges until seen), then records one frame up to frame_done.
  task automatic capture0(input int drop_at);
    int k;
    log0.delete();
    vs0 = 0; nz0 = 0; done0 = 0; to0 = 0;
    k = 0;
    do begin
      @(negedge PCLK);
      k++;
    end while (bus0.VSYNC !== 1'b1 && k < 100);
    lat0 = k;
    if (bus0.VSYNC !== 1'b1) to0 = 1;
    while (to0 == 0 && done0 == 0) begin
      if (bus0.VSYNC === 1'b1) vs0++;
      if (bus0.pixel_valid === 1'b1) begin
        log0.push_back(bus0.pixel_in);
        if (drop_at >= 0 && log0.size() == drop_at) en0 = 1'b0;
      end else if (bus0.pixel_in !== 16'h0000) nz0++;
      if (bus0.frame_done === 1'b1) done0 = 1;
      else begin
        @(negedge PCLK);
        k++;
        if (k > 400) to0 = 1;
      end
    end
  endtask

  task automatic test_reset;
    rst0 = 1'b1; en0 = 1'b1;
    repeat (3) @(negedge PCLK);
    vectors++; if (bus0.VSYNC !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b expected 0", bus0.VSYNC); end
    vectors++; if (bus0.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus0.pixel_valid); end
    vectors++; if (bus0.pixel_in !== 16'h0000) begin errors++; $display("FAIL reset_pixel: got %h expected 0000", bus0.pixel_in); end
    vectors++; if (bus0.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus0.frame_done); end
    vectors++; if (bus0.frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_fcnt: got %h expected 0000", bus0.frame_cnt); end
  endtask

  task automatic test_counter_frame;
    sel0 = 2'd3; en0 = 1'b1; rst0 = 1'b0;
    capture0(-1);
    vectors++; if (to0 != 0) begin errors++; $display("FAIL cnt_timeout: got %0d expected 0", to0); end
    vectors++; if (lat0 != 4) begin errors++; $display("FAIL cnt_first_vsync: got %0d expected 4", lat0); end
    vectors++; if (vs0 != 40) begin errors++; $display("FAIL cnt_vsync_len: got %0d expected 40", vs0); end
    vectors++; if (log0.size() != 32) begin errors++; $display("FAIL cnt_npix: got %0d expected 32", log0.size()); end
    for (int i = 0; i < log0.size(); i++) begin
      vectors++;
      if (log0[i] !== 16'(i)) begin errors++; $display("FAIL cnt_pix%0d: got %h expected %h", i, log0[i], 16'(i)); end
    end
    vectors++; if (nz0 != 0) begin errors++; $display("FAIL cnt_blank_zero: got %0d expected 0", nz0); end
    vectors++; if (done0 != 1) begin errors++; $display("FAIL cnt_done: got %0d expected 1", done0); end
    vectors++; if (bus0.frame_cnt !== 16'd1) begin errors++; $display("FAIL cnt_fcnt: got %h expected 0001", bus0.frame_cnt); end
    @(negedge PCLK);
    vectors++; if (bus0.frame_done !== 1'b0) begin errors++; $display("FAIL cnt_done_pulse: got %b expected 0", bus0.frame_done); end
  endtask

  task automatic test_back_to_back;
    capture0(-1);
    // One gap negedge was already consumed by the pulse check, so 2 of the 3 gap cycles remain.
    vectors++; if (lat0 != 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2", lat0); end
    vectors++; if (vs0 != 40) begin errors++; $display("FAIL b2b_vsync_len: got %0d expected 40", vs0); end
    vectors++; if (log0.size() != 32) begin errors++; $display("FAIL b2b_npix: got %0d expected 32", log0.size()); end
    for (int i = 0; i < log0.size(); i++) begin
      vectors++;
      if (log0[i] !== 16'(i)) begin errors++; $display("FAIL b2b_pix%0d: got %h expected %h", i, log0[i], 16'(i)); end
    end
    vectors++; if (bus0.frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_fcnt: got %h expected 0002", bus0.frame_cnt); end
  endtask

  task automatic test_enable_drop;
    int hi;
    capture0(17);
    vectors++; if (lat0 != 3) begin errors++; $display("FAIL drop_gap: got %0d expected 3", lat0); end
    vectors++; if (log0.size() != 32) begin errors++; $display("FAIL drop_npix: got %0d expected 32", log0.size()); end
    vectors++; if (vs0 != 40) begin errors++; $display("FAIL drop_vsync_len: got %0d expected 40", vs0); end
    vectors++; if (done0 != 1) begin errors++; $display("FAIL drop_done: got %0d expected 1", done0); end
    vectors++; if (bus0.frame_cnt !== 16'd3) begin errors++; $display("FAIL drop_fcnt: got %h expected 0003", bus0.frame_cnt); end
    hi = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (bus0.VSYNC !== 1'b0 || bus0.pixel_valid !== 1'b0) hi++;
    end
    vectors++; if (hi != 0) begin errors++; $display("FAIL drop_idle: got %0d active cycles expected 0", hi); end
  endtask

  task automatic test_patterns_small;
    logic [15:0] exp;
    sel0 = 2'd0; en0 = 1'b1;
    capture0(-1);
    sel0 = 2'd1;
    vectors++; if (lat0 != 4) begin errors++; $display("FAIL bars8_start: got %0d expected 4", lat0); end
    vectors++; if (log0.size() != 32) begin errors++; $display("FAIL bars8_npix: got %0d expected 32", log0.size()); end
    for (int i = 0; i < log0.size(); i++) begin
      exp = bars[i % 8];
      vectors++;
      if (log0[i] !== exp) begin errors++; $display("FAIL bars8_pix%0d: got %h expected %h", i, log0[i], exp); end
    end
    capture0(1);
    vectors++; if (log0.size() != 32) begin errors++; $display("FAIL grad8_npix: got %0d expected 32", log0.size()); end
    for (int i = 0; i < log0.size(); i++) begin
      exp = 16'(((i % 8) << 8) | (i / 8));
      vectors++;
      if (log0[i] !== exp) begin errors++; $display("FAIL grad8_pix%0d: got %h expected %h", i, log0[i], exp); end
    end
    vectors++; if (bus0.frame_cnt !== 16'd5) begin errors++; $display("FAIL grad8_fcnt: got %h expected 0005", bus0.frame_cnt); end
  endtask

  task automatic test_reset_midline;
    int k;
    sel0 = 2'd3; en0 = 1'b1;
    k = 0;
    do begin
      @(negedge PCLK);
      k++;
    end while (!(bus0.pixel_valid === 1'b1 && bus0.pixel_in === 16'd5) && k < 100);
    vectors++; if (k >= 100) begin errors++; $display("FAIL mid_reach_h5: got timeout expected pixel 5"); end
    rst0 = 1'b1;
    @(negedge PCLK);
    vectors++; if (bus0.VSYNC !== 1'b0) begin errors++; $display("FAIL mid_vsync: got %b expected 0", bus0.VSYNC); end
    vectors++; if (bus0.pixel_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus0.pixel_valid); end
    vectors++; if (bus0.pixel_in !== 16'h0000) begin errors++; $display("FAIL mid_pixel: got %h expected 0000", bus0.pixel_in); end
    vectors++; if (bus0.frame_cnt !== 16'h0000) begin errors++; $display("FAIL mid_fcnt: got %h expected 0000", bus0.frame_cnt); end
    rst0 = 1'b0;
    capture0(-1);
    vectors++; if (lat0 != 4) begin errors++; $display("FAIL mid_regap: got %0d expected 4", lat0); end
    vectors++; if (log0.size() != 32 || log0[0] !== 16'h0000 || log0[31] !== 16'd31) begin
      errors++; $display("FAIL mid_refresh: got %0d pixels expected 32 valued 0..31", log0.size());
    end
    vectors++; if (bus0.frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_fcnt_after: got %h expected 0001", bus0.frame_cnt); end
  endtask

  task automatic test_wrap;
    force dut0.frame_count = 16'hFFFF;
    @(negedge PCLK);
    release dut0.frame_count;
    capture0(1);
    vectors++; if (done0 != 1) begin errors++; $display("FAIL wrap_done: got %0d expected 1", done0); end
    vectors++; if (bus0.frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_fcnt: got %h expected 0000", bus0.frame_cnt); end
    @(negedge PCLK);
    vectors++; if (bus0.frame_done !== 1'b0) begin errors++; $display("FAIL wrap_pulse: got %b expected 0", bus0.frame_done); end
  endtask

  task automatic wait_big(input int target_frames, input string name);
    int k;
    k = 0;
    while (frames1 < target_frames && k < 6000) begin
      @(negedge PCLK);
      k++;
    end
    vectors++; if (frames1 < target_frames) begin errors++; $display("FAIL %s_timeout: got %0d frames expected %0d", name, frames1, target_frames); end
  endtask

  task automatic wait_idx(input int n);
    int k;
    k = 0;
    while (idx1 < n && k < 3000) begin
      @(negedge PCLK);
      k++;
    end
  endtask

  task automatic test_color_bars;
    rst1 = 1'b1;
    repeat (2) @(negedge PCLK);
    nz1 = 0; blanks1 = 0; blank_bad1 = 0;
    sel1 = 2'd0; en1 = 1'b1; rst1 = 1'b0;
    wait_idx(700);
    sel1 = 2'd2;
    wait_big(1, "bars");
    vectors++; if (fb1[79] !== 16'hFFFF) begin errors++; $display("FAIL bars_h79: got %h expected FFFF", fb1[79]); end
    vectors++; if (fb1[80] !== 16'hFFE0) begin errors++; $display("FAIL bars_h80: got %h expected FFE0", fb1[80]); end
    vectors++; if (fb1[400] !== 16'hF800) begin errors++; $display("FAIL bars_h400: got %h expected F800", fb1[400]); end
    vectors++; if (fb1[639] !== 16'h0000) begin errors++; $display("FAIL bars_h639: got %h expected 0000", fb1[639]); end
    vectors++; if (fb1[720] !== 16'hFFE0) begin errors++; $display("FAIL bars_sel_hold: got %h expected FFE0", fb1[720]); end
    vectors++; if (blanks1 != 3) begin errors++; $display("FAIL bars_nblank: got %0d expected 3", blanks1); end
    vectors++; if (blank_bad1 != 0) begin errors++; $display("FAIL bars_blank_len: got %0d wrong-length blanks expected 0", blank_bad1); end
    vectors++; if (nz1 != 0) begin errors++; $display("FAIL bars_idle_pixel: got %0d nonzero expected 0", nz1); end
  endtask

  task automatic test_pattern_switch;
    int hi;
    wait_idx(700);
    sel1 = 2'd1;
    wait_big(2, "checker");
    vectors++; if (fb1[32] !== 16'hFFFF) begin errors++; $display("FAIL chk_h32v0: got %h expected FFFF", fb1[32]); end
    vectors++; if (fb1[0] !== 16'h0000) begin errors++; $display("FAIL chk_h0v0: got %h expected 0000", fb1[0]); end
    vectors++; if (fb1[640 + 32] !== 16'hFFFF) begin errors++; $display("FAIL chk_hold_h32v1: got %h expected FFFF", fb1[672]); end
    wait_idx(5);
    en1 = 1'b0;
    wait_big(3, "grad");
    vectors++; if (fb1[2*640 + 3] !== 16'h0302) begin errors++; $display("FAIL grad_h3v2: got %h expected 0302", fb1[1283]); end
    vectors++; if (fb1[640 + 255] !== 16'hFF01) begin errors++; $display("FAIL grad_h255v1: got %h expected FF01", fb1[895]); end
    hi = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (bus1.VSYNC !== 1'b0) hi++;
    end
    vectors++; if (hi != 0) begin errors++; $display("FAIL grad_idle: got %0d vsync cycles expected 0", hi); end
    vectors++; if (bus1.frame_cnt !== 16'd3) begin errors++; $display("FAIL grad_fcnt: got %h expected 0003", bus1.frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_counter_frame();
    test_back_to_back();
    test_enable_drop();
    test_patterns_small();
    test_reset_midline();
    test_wrap();
    test_color_bars();
    test_pattern_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cam_stream_gen.md
CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 Parameter CAM_WIDTH, default 640, active pixels per line.
REQ-002 Parameter CAM_HEIGHT, default 480, active lines per frame.
REQ-003 Parameter H_BLANK, default 144, idle cycles after each line (VSYNC high, pixel_valid low); legal range >=1.
REQ-004 Parameter V_GAP, default 1000, cycles with VSYNC low between frames; legal range >=1.
REQ-005 PCLK  input  1  sole clock; all logic on rising edge. One clock; reset is synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 enable  input  1  run request; sampled only at frame boundaries.
REQ-008 pattern_sel  input  2  test pattern select; sampled at frame start.
REQ-009 VSYNC  output  1  high for the whole frame (active lines plus their HBLANKs), low in gap/idle.
REQ-010 pixel_valid  output  1  high for exactly one pixel per cycle during active pixels.
REQ-011 pixel_in  output  16  RGB565 pixel, meaningful only when pixel_valid=1, else 16'h0000.
REQ-012 frame_done  output  1  one-cycle pulse at end of each frame.
REQ-013 frame_cnt  output  16  completed-frame count.

Function
REQ-014 States SHALL be IDLE, VGAP, ACTIVE and HBLANK; all outputs registered, Moore-style.
REQ-015 IDLE: VSYNC=0, pixel_valid=0; when enable=1, go to VGAP.
REQ-016 VGAP: VSYNC=0 for exactly V_GAP cycles, then ACTIVE with h_cnt=0, v_cnt=0, latched pattern_sel.
REQ-017 ACTIVE: VSYNC=1, pixel_valid=1 for exactly CAM_WIDTH consecutive cycles, h_cnt 0..CAM_WIDTH-1, then HBLANK.
REQ-018 HBLANK: VSYNC=1, pixel_valid=0 for exactly H_BLANK cycles; then ACTIVE with v_cnt+1 if v_cnt<CAM_HEIGHT-1.
REQ-019 After HBLANK of line CAM_HEIGHT-1: frame_done=1 for one cycle, frame_cnt+1 (wraps 16'hFFFF->0); next state VGAP if enable=1, else IDLE.
REQ-020 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes, then IDLE.
REQ-021 pattern_sel changes mid-frame SHALL take effect only at the next frame start.
REQ-022 Pattern 0 (color bars): bar = h_cnt/(CAM_WIDTH/8), clamped to 7; colors in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-023 Pattern 1 (gradient): pixel_in = {h_cnt[7:0], v_cnt[7:0]}.
REQ-024 Pattern 2 (checker): pixel_in = (h_cnt[5]^v_cnt[5]) ? 16'hFFFF : 16'h0000.
REQ-025 Pattern 3 (counter): 16-bit count, 0 at first pixel of frame, +1 per valid pixel, wraps at 16 bits.
REQ-026 pixel_in SHALL be 16'h0000 whenever pixel_valid=0.
REQ-027 Per frame exactly CAM_WIDTH*CAM_HEIGHT valid pixels; VSYNC high exactly CAM_HEIGHT*(CAM_WIDTH+H_BLANK) cycles.
REQ-028 h_cnt/v_cnt widths SHALL be $clog2 of CAM_WIDTH/CAM_HEIGHT; counters never exceed their limits.

Reset
REQ-029 rst=1 at any cycle, including mid-line: next edge state=IDLE, VSYNC=0, pixel_valid=0, pixel_in=0, frame_done=0, frame_cnt=0, h_cnt=v_cnt=0.
REQ-030 rst SHALL dominate enable on the same edge; after release, first VSYNC rise no earlier than V_GAP+1 cycles.

Verification
REQ-031 rst, enable=1, pattern 3, CAM_WIDTH=8, CAM_HEIGHT=4, H_BLANK=2, V_GAP=3 -> VSYNC high 40 cycles, 32 valid pixels valued 0..31, frame_done once, frame_cnt=1.
REQ-032 Pattern 0 defaults -> pixel at h_cnt=79 is FFFF, h_cnt=80 is FFE0, h_cnt=639 is 0000; pixel_valid low during each 144-cycle HBLANK.
REQ-033 Drop enable at line 100 of frame 0 -> frame completes all 480 lines, frame_done pulses, state IDLE, VSYNC stays 0.
REQ-034 Change pattern_sel 2->1 mid-frame -> current frame stays checker (h=32,v=0 gives FFFF); next frame gradient (h=3,v=2 gives 0x0302).
REQ-035 Assert rst during ACTIVE at h_cnt=5 -> next cycle all outputs 0, frame_cnt=0; after release, full V_GAP before VSYNC rises.
REQ-036 Force frame_cnt to 16'hFFFF, finish one frame -> frame_cnt=0, frame_done single pulse.
